// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV64 pipeline: load-use, redirect, and I/D memory waits.
// Define HAZARD_PERF_EN to add the saturating cnt_lu / cnt_dmem / cnt_flush event counters.
module hazard_ctrl #(
  parameter int XLEN = 64,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  ID_rs1,
  input  logic [RAW-1:0]  ID_rs2,
  input  logic            ID_use_rs1,
  input  logic            ID_use_rs2,
  input  logic [RAW-1:0]  EX_rd,
  input  logic            EX_mem_read,
  input  logic            EX_redirect,
  input  logic [XLEN-1:0] EX_target,
  input  logic            imem_req,
  input  logic            imem_ack,
  input  logic            dmem_req,
  input  logic            dmem_ack,
  output logic            stall_PC,
  output logic            stall_IFID,
  output logic            stall_IDEX,
  output logic            stall_EXMEM,
  output logic            flush_IFID,
  output logic            flush_IDEX,
  output logic            bubble_MEMWB,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     cnt_lu,
  output logic [31:0]     cnt_dmem,
  output logic [31:0]     cnt_flush
`endif
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DMEM_WAIT,
    S_IMEM_WAIT,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pend_target_q, pend_target_d;
  logic              fire_q, fire_d;

  logic dstall;
  logic istall;
  logic lu;
  logic mem_hold;

  assign dstall = dmem_req & ~dmem_ack;
  assign istall = imem_req & ~imem_ack;
  assign lu     = EX_mem_read & (EX_rd != '0) &
                  ((ID_use_rs1 & (EX_rd == ID_rs1)) | (ID_use_rs2 & (EX_rd == ID_rs2)));

  // DMEM_WAIT keeps the back end frozen until the ack, even if the request line wobbles.
  assign mem_hold = dstall | ((state_q == S_DMEM_WAIT) & ~dmem_ack);

  always_comb begin
    // NOTE: every output and next-state signal gets a default first so no path infers a latch.
    stall_PC       = 1'b0;
    stall_IFID     = 1'b0;
    stall_IDEX     = 1'b0;
    stall_EXMEM    = 1'b0;
    flush_IFID     = 1'b0;
    flush_IDEX     = 1'b0;
    bubble_MEMWB   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    state_d        = state_q;
    pend_target_d  = pend_target_q;
    fire_d         = 1'b0;

    if (state_q == S_DRAIN) begin
      stall_PC   = 1'b1;
      flush_IFID = 1'b1;
      if (fire_q) begin
        // Stale fetch has retired: the PC must load the deferred target, so it is not held.
        stall_PC       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = pend_target_q;
        state_d        = dstall ? S_DMEM_WAIT : S_RUN;
      end else if (imem_ack) begin
        fire_d = 1'b1;
      end
      if (dstall) begin
        stall_IDEX   = 1'b1;
        stall_EXMEM  = 1'b1;
        bubble_MEMWB = 1'b1;
      end
    end else if (mem_hold) begin
      stall_PC     = 1'b1;
      stall_IFID   = 1'b1;
      stall_IDEX   = 1'b1;
      stall_EXMEM  = 1'b1;
      bubble_MEMWB = 1'b1;
      state_d      = S_DMEM_WAIT;
    end else if (EX_redirect) begin
      if (!istall) begin
        redirect_valid = 1'b1;
        redirect_pc    = EX_target;
        flush_IFID     = 1'b1;
        flush_IDEX     = 1'b1;
        state_d        = S_RUN;
      end else begin
        pend_target_d = EX_target;
        flush_IDEX    = 1'b1;
        stall_PC      = 1'b1;
        state_d       = S_DRAIN;
      end
    end else if (lu) begin
      // Holding IF/ID keeps the dependent instruction; it must not also be flushed.
      stall_PC   = 1'b1;
      stall_IFID = 1'b1;
      flush_IDEX = 1'b1;
      state_d    = istall ? S_IMEM_WAIT : S_RUN;
    end else if (istall) begin
      stall_PC   = 1'b1;
      flush_IFID = 1'b1;
      state_d    = S_IMEM_WAIT;
    end else begin
      state_d = S_RUN;
    end

    if (rst) begin
      stall_PC       = 1'b0;
      stall_IFID     = 1'b0;
      stall_IDEX     = 1'b0;
      stall_EXMEM    = 1'b0;
      flush_IFID     = 1'b1;
      flush_IDEX     = 1'b1;
      bubble_MEMWB   = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      pend_target_q <= '0;
      fire_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      fire_q        <= fire_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic lu_hit;
  assign lu_hit = lu & ~mem_hold & ~EX_redirect & (state_q != S_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lu    <= '0;
      cnt_dmem  <= '0;
      cnt_flush <= '0;
    end else begin
      if (lu_hit && (cnt_lu != '1))
        cnt_lu <= cnt_lu + 32'd1;
      if (dstall && (cnt_dmem != '1))
        cnt_dmem <= cnt_dmem + 32'd1;
      if (redirect_valid && (cnt_flush != '1))
        cnt_flush <= cnt_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vectors with literal expectations plus a per-cycle model.
module tb_hazard_ctrl;

  localparam int XLEN = 64;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [RAW-1:0]  ID_rs1, ID_rs2, EX_rd;
  logic            ID_use_rs1, ID_use_rs2, EX_mem_read, EX_redirect;
  logic [XLEN-1:0] EX_target;
  logic            imem_req, imem_ack, dmem_req, dmem_ack;
  logic            stall_PC, stall_IFID, stall_IDEX, stall_EXMEM;
  logic            flush_IFID, flush_IDEX, bubble_MEMWB, redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_rd(EX_rd), .EX_mem_read(EX_mem_read), .EX_redirect(EX_redirect), .EX_target(EX_target),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX), .stall_EXMEM(stall_EXMEM),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .bubble_MEMWB(bubble_MEMWB),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Control outputs packed MSB first: sPC sIFID sIDEX sEXMEM fIFID fIDEX bMEMWB rv
  wire [7:0] outs = {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
                     flush_IFID, flush_IDEX, bubble_MEMWB, redirect_valid};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model context: a memory wait in progress, a redirect owed behind a fetch, and whether it is due now.
  bit              m_mem_wait;
  bit              m_drain;
  bit              m_due;
  logic [XLEN-1:0] m_pend;

  function automatic bit f_dstall();
    return dmem_req && !dmem_ack;
  endfunction

  function automatic bit f_istall();
    return imem_req && !imem_ack;
  endfunction

  function automatic bit f_lu();
    return EX_mem_read && (EX_rd != 0) &&
           ((ID_use_rs1 && EX_rd == ID_rs1) || (ID_use_rs2 && EX_rd == ID_rs2));
  endfunction

  function automatic bit f_mem_busy();
    return f_dstall() || (m_mem_wait && !dmem_ack);
  endfunction

  function automatic void model_out(output logic [7:0] v, output logic [63:0] pc);
    bit s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, bub, rv;
    {s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, bub, rv} = 8'h00;
    pc = 64'h0;
    if (rst) begin
      v = 8'h0E;
      return;
    end
    if (m_drain) begin
      if (m_due) begin
        rv = 1; f_ifid = 1; pc = m_pend;
      end else begin
        s_pc = 1; f_ifid = 1;
      end
      if (f_dstall()) begin
        s_idex = 1; s_exmem = 1; bub = 1;
      end
    end else if (f_mem_busy()) begin
      s_pc = 1; s_ifid = 1; s_idex = 1; s_exmem = 1; bub = 1;
    end else if (EX_redirect && !f_istall()) begin
      rv = 1; pc = EX_target; f_ifid = 1; f_idex = 1;
    end else if (EX_redirect) begin
      s_pc = 1; f_idex = 1;
    end else if (f_lu()) begin
      s_pc = 1; s_ifid = 1; f_idex = 1;
    end else if (f_istall()) begin
      s_pc = 1; f_ifid = 1;
    end
    v = {s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, bub, rv};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mem_wait <= 0;
      m_drain    <= 0;
      m_due      <= 0;
      m_pend     <= '0;
    end else if (m_drain) begin
      if (m_due) begin
        m_drain    <= 0;
        m_due      <= 0;
        m_mem_wait <= f_dstall();
      end else if (imem_ack) begin
        m_due <= 1;
      end
    end else begin
      m_mem_wait <= f_mem_busy();
      if (!f_mem_busy() && EX_redirect && f_istall()) begin
        m_drain <= 1;
        m_pend  <= EX_target;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0]  ev;
    logic [63:0] epc;
    model_out(ev, epc);
    check("model_ctl", {56'h0, outs}, {56'h0, ev});
    check("model_pc", redirect_pc, epc);
  end

  task automatic idle();
    ID_rs1 = '0; ID_rs2 = '0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    EX_rd = '0; EX_mem_read = 0; EX_redirect = 0; EX_target = '0;
    imem_req = 0; imem_ack = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_vec(input string name, input logic [7:0] v, input logic [63:0] pc);
    #3;
    check({name, "_ctl"}, {56'h0, outs}, {56'h0, v});
    check({name, "_pc"}, redirect_pc, pc);
  endtask

  task automatic set_lu(input logic [RAW-1:0] rd);
    EX_mem_read = 1; EX_rd = rd; ID_rs1 = rd; ID_use_rs1 = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle();
    EX_redirect = 1; EX_target = 64'h1234; imem_req = 1;
    tick();
    expect_vec("reset", 8'h0E, 64'h0);
    tick();
    idle();
    rst = 0;
    expect_vec("after_reset", 8'h00, 64'h0);
    tick();

    set_lu(5);
    expect_vec("lu_rs1", 8'hC4, 64'h0);
    tick();
    idle();
    expect_vec("lu_release", 8'h00, 64'h0);
    tick();

    set_lu(0);
    expect_vec("lu_rd0", 8'h00, 64'h0);
    tick();

    idle();
    EX_mem_read = 1; EX_rd = 7; ID_rs2 = 7; ID_use_rs2 = 1; ID_rs1 = 7;
    expect_vec("lu_rs2", 8'hC4, 64'h0);
    tick();

    idle();
    EX_mem_read = 1; EX_rd = 9; ID_rs1 = 9; ID_use_rs1 = 0; ID_rs2 = 3; ID_use_rs2 = 1;
    expect_vec("lu_unused_src", 8'h00, 64'h0);
    tick();

    idle();
    EX_redirect = 1; EX_target = 64'h8000_0040;
    expect_vec("redirect_now", 8'h0D, 64'h8000_0040);
    tick();

    idle();
    imem_req = 1;
    expect_vec("istall", 8'h88, 64'h0);
    tick();
    imem_ack = 1;
    expect_vec("imem_ack", 8'h00, 64'h0);
    tick();

    idle();
    imem_req = 1;
    set_lu(12);
    expect_vec("lu_istall", 8'hC4, 64'h0);
    tick();
    idle();
    tick();

    EX_redirect = 1; EX_target = 64'h8000_1000; imem_req = 1;
    expect_vec("drain_enter", 8'h84, 64'h0);
    tick();
    idle();
    imem_req = 1;
    for (int i = 0; i < 2; i++) begin
      expect_vec("drain_wait", 8'h88, 64'h0);
      tick();
    end
    imem_ack = 1;
    expect_vec("drain_ack", 8'h88, 64'h0);
    tick();
    idle();
    expect_vec("drain_fire", 8'h09, 64'h8000_1000);
    tick();
    expect_vec("drain_done", 8'h00, 64'h0);
    tick();

    dmem_req = 1; set_lu(4); EX_redirect = 1; EX_target = 64'h8000_2000;
    for (int i = 0; i < 4; i++) begin
      expect_vec("dmem_wait", 8'hF2, 64'h0);
      tick();
    end
    dmem_ack = 1;
    expect_vec("dmem_ack_redirect", 8'h0D, 64'h8000_2000);
    tick();
    idle();
    expect_vec("dmem_done", 8'h00, 64'h0);
    tick();

    EX_redirect = 1; EX_target = 64'h8000_3000; imem_req = 1;
    expect_vec("drain2_enter", 8'h84, 64'h0);
    tick();
    idle();
    imem_req = 1; dmem_req = 1;
    expect_vec("drain_dstall", 8'hBA, 64'h0);
    tick();
    dmem_ack = 1; imem_ack = 1;
    expect_vec("drain2_ack", 8'h88, 64'h0);
    tick();
    idle();
    expect_vec("drain2_fire", 8'h09, 64'h8000_3000);
    tick();

    EX_redirect = 1; EX_target = 64'h8000_4000; imem_req = 1;
    expect_vec("drain3_enter", 8'h84, 64'h0);
    tick();
    idle();
    imem_req = 1;
    expect_vec("drain3_wait", 8'h88, 64'h0);
    rst = 1;
    #1;
    check("rst_async_ctl", {56'h0, outs}, 64'h0E);
    check("rst_async_pc", redirect_pc, 64'h0);
    tick();
    rst = 0;
    idle();
    imem_ack = 1;
    expect_vec("post_rst_ack", 8'h00, 64'h0);
    tick();
    idle();
    expect_vec("post_rst_no_redirect", 8'h00, 64'h0);
    tick();
    expect_vec("post_rst_idle", 8'h00, 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage 64-bit RISC-V core. It is the counterpart to the ID-stage operand forwarding logic: it detects the cases forwarding cannot resolve, which are load-use, a taken branch/jump redirect, and instruction or data memory wait states. For each case it drives per-stage stall, flush and redirect controls. It owns a small FSM that tracks outstanding memory waits and a redirect that must be deferred behind a busy fetch.

Parameters:
XLEN, 64, width of PC and redirect target
RAW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ID_rs1  in  RAW  source reg 1 of instruction in ID
ID_rs2  in  RAW  source reg 2 of instruction in ID
ID_use_rs1  in  1  ID instruction reads rs1
ID_use_rs2  in  1  ID instruction reads rs2
EX_rd  in  RAW  destination reg in EX
EX_mem_read  in  1  EX instruction is a load
EX_redirect  in  1  EX resolved taken branch/jump
EX_target  in  XLEN  redirect target PC
imem_req  in  1  fetch request outstanding this cycle
imem_ack  in  1  fetch data valid
dmem_req  in  1  MEM-stage access outstanding
dmem_ack  in  1  data access complete
stall_PC  out  1  hold PC
stall_IFID  out  1  hold IF/ID
stall_IDEX  out  1  hold ID/EX
stall_EXMEM  out  1  hold EX/MEM
flush_IFID  out  1  load NOP into IF/ID
flush_IDEX  out  1  load NOP into ID/EX
bubble_MEMWB  out  1  load NOP into MEM/WB
redirect_valid  out  1  PC loads redirect_pc
redirect_pc  out  XLEN  redirect target

Behaviour:
- Outputs are combinational from state plus inputs. State, pend_target and counters are registered.
- States: RUN, DMEM_WAIT, IMEM_WAIT, DRAIN.
- While rst=1, and immediately on assertion (async): state=RUN, pend_target=0. Outputs: flush_IFID=1, flush_IDEX=1, bubble_MEMWB=1, all others 0, redirect_pc=0.
- Signal definitions:
  - dstall = dmem_req & ~dmem_ack
  - istall = imem_req & ~imem_ack
  - lu = EX_mem_read & EX_rd!=0 & ((ID_use_rs1 & EX_rd==ID_rs1) | (ID_use_rs2 & EX_rd==ID_rs2))
- Priority in RUN/IMEM_WAIT: dstall > EX_redirect > lu > istall.
- dstall (any state except DRAIN, which keeps its own rule):
  - stall_PC, stall_IFID, stall_IDEX, stall_EXMEM = 1; bubble_MEMWB=1; next state DMEM_WAIT.
  - EX_redirect and lu are ignored that cycle, because EX is held and will re-present them.
- DMEM_WAIT: the same outputs hold while ~dmem_ack. In the dmem_ack cycle, the RUN rules apply and the next state is RUN.
- EX_redirect, no dstall:
  - If ~istall: redirect_valid=1, redirect_pc=EX_target, flush_IFID=1, flush_IDEX=1; state RUN.
  - If istall: latch pend_target=EX_target, flush_IDEX=1, stall_PC=1, go DRAIN.
- DRAIN:
  - stall_PC=1 and flush_IFID=1 every cycle.
  - On imem_ack, the stale fetch is discarded; the next cycle asserts redirect_valid=1 with redirect_pc=pend_target, then state RUN.
  - A dstall in DRAIN additionally asserts stall_EXMEM, stall_IDEX and bubble_MEMWB; DRAIN is kept.
- lu, no dstall/redirect: stall_PC=1, stall_IFID=1, flush_IDEX=1 for exactly one cycle. No state change, because the load advances to MEM and lu drops.
- istall only: stall_PC=1, flush_IFID=1; state IMEM_WAIT until imem_ack, then RUN.
- Simultaneous lu and istall: lu outputs plus flush_IFID=0; stall_IFID wins.
- EX_rd=0 never causes lu.
- Reset mid-DRAIN drops the pending redirect.
- redirect_pc = EX_target when redirect_valid comes from RUN, pend_target when from DRAIN, else 0.

Optional Feature:
- HAZARD_PERF_EN defined: adds three 32-bit outputs, cnt_lu, cnt_dmem and cnt_flush.
  - cnt_lu increments per lu cycle.
  - cnt_dmem increments per dstall cycle.
  - cnt_flush increments per redirect_valid.
  - All three saturate at 0xFFFFFFFF and clear on rst.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Load in EX with EX_rd=5, ID_rs1=5, ID_use_rs1=1 -> one cycle stall_PC=stall_IFID=flush_IDEX=1; next cycle all 0.
- Same as above with EX_rd=0 -> no stall.
- EX_redirect=1, EX_target=0x80000040, imem idle -> same cycle redirect_valid=1, redirect_pc=0x80000040, flush_IFID=flush_IDEX=1.
- EX_redirect with imem_req=1, imem_ack=0 for 3 cycles -> DRAIN: stall_PC=1 and flush_IFID=1 each cycle; the cycle after ack shows redirect_valid=1, redirect_pc=latched target.
- dmem_req=1, ack delayed 4 cycles, with lu and EX_redirect also present -> 4 cycles of all stalls plus bubble_MEMWB, no redirect; the ack cycle applies the redirect.
- rst pulse asserted mid-DRAIN -> outputs go to reset values immediately; after release, no redirect_valid.
